// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t : controller state encoding (IDLE / RUN / DONE)
//   - cnt_width() : bit-position counter width, max(1, clog2(W))
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter only needs to reach W-1. A W=1 build still needs one bit
  // so the counter is a real signal.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell
// Purely combinational 1-bit full adder. It is the single arithmetic cell
// that the serial adder time-shares across every bit position.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   c    : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ ci;
  assign c = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller. The operands are walked LSB-first through one
// shared fa_cell, one bit per clock. {cout,sum} = a + b + cin, unsigned.
// A start is accepted in IDLE or DONE. RUN then lasts W cycles, and done
// pulses for one cycle. Back-to-back operation gives one add every W+1 cycles.
// Optional build macro: SERIAL_ADD_CTRL_OVF_EN adds the ovf output, which is
// two's-complement overflow registered together with sum.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE or DONE
//   a, b  : W-bit operands, captured on the accepted start
//   cin   : carry in, captured on the accepted start
//   busy  : high while in RUN
//   done  : one-cycle pulse, result valid
//   sum   : registered result, held until the next done
//   cout  : registered carry out, held with sum
//   ovf   : (SERIAL_ADD_CTRL_OVF_EN only) registered signed overflow
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADD_CTRL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_width(W);

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, b_reg;
  logic           c_reg;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   sum_reg;
  logic           cout_reg;

  logic           fa_s, fa_c;
  logic [W-1:0]   s_shift;   // partial sum with this cycle's bit shifted in at the MSB
  logic           last_bit;
  logic           accept;

  fa_cell u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (c_reg),
    .s  (fa_s),
    .c  (fa_c)
  );

  assign last_bit = (cnt_reg == CW'(W - 1));
  assign accept   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // The sum shift register only has to hold the W-1 bits that were produced
  // before the final cycle. The last bit comes straight from the cell and
  // joins the held bits as they are written into sum_reg. A W=1 build needs
  // no storage at all.
  generate
    if (W == 1) begin : g_w1
      assign s_shift = fa_s;
    end else begin : g_wn
      logic [W-2:0] s_part_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s_part_reg <= '0;
        end else if (state_reg == ST_RUN) begin
          s_part_reg <= s_shift[W-1:1];
        end
      end

      assign s_shift = {fa_s, s_part_reg};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        c_reg   <= cin;
        cnt_reg <= '0;
      end else if (state_reg == ST_RUN) begin
        a_reg   <= a_reg >> 1;
        b_reg   <= b_reg >> 1;
        c_reg   <= fa_c;
        cnt_reg <= cnt_reg + CW'(1);
        if (last_bit) begin
          sum_reg  <= s_shift;
          cout_reg <= fa_c;
        end
      end
    end
  end

`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic ovf_reg;

  // On the last RUN cycle c_reg is the carry into the MSB and fa_c is the
  // carry out of it. When they differ, the signed result has overflowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if ((state_reg == ST_RUN) && last_bit && !accept) begin
      ovf_reg <= c_reg ^ fa_c;
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Scoreboard bench for serial_add_ctrl. It drives a W=8 instance and a W=1
// instance. When the driver issues an operation, it pushes the hand-computed
// result and the expected done cycle into a queue. A monitor per instance
// pops an entry and compares it on every done pulse.
// Also honours SERIAL_ADD_CTRL_OVF_EN (ovf port and ovf checks).
module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8, sum8;
  logic       cin8, busy8, done8, cout8;
  logic [0:0] a1, b1, sum1;
  logic       cin1, busy1, done1, cout1;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic       ovf8, ovf1;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && done8) begin
      chk("w8_busy_with_done", int'(busy8), 0);
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_sum", int'(sum8), int'(e.sum));
        chk("w8_cout", int'(cout8), int'(e.cout));
        chk("w8_done_cycle", cyc, e.cyc);
`ifdef SERIAL_ADD_CTRL_OVF_EN
        chk("w8_ovf", int'(ovf8), int'(e.ovf));
`endif
        $display("w8 txn: sum=0x%02h cout=%0d at cycle %0d", sum8, cout8, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      chk("w1_busy_with_done", int'(busy1), 0);
      if (q1.size() == 0) begin
        chk("w1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("w1_sum", int'(sum1), int'(e.sum[0]));
        chk("w1_cout", int'(cout1), int'(e.cout));
        chk("w1_done_cycle", cyc, e.cyc);
`ifdef SERIAL_ADD_CTRL_OVF_EN
        chk("w1_ovf", int'(ovf1), int'(e.ovf));
`endif
        $display("w1 txn: sum=%0d cout=%0d at cycle %0d", sum1, cout1, cyc);
      end
    end
  end

  // Issue one add on the W=8 instance. The operands are then scrambled while
  // busy, to show that only the captured values are used.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = ~ta; b8 = tb ^ 8'h5A; cin8 = ~tc;
    repeat (9) @(negedge clk);
  endtask

  // Directed vectors for back-to-back operation: {a, b, cin, sum, cout, ovf}.
  logic [7:0] bb_a [3] = '{8'h12, 8'hC8, 8'hA5};
  logic [7:0] bb_b [3] = '{8'h34, 8'h64, 8'h5A};
  logic       bb_c [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] bb_s [3] = '{8'h47, 8'h2C, 8'h00};
  logic       bb_co[3] = '{1'b0, 1'b1, 1'b1};
  logic       bb_o [3] = '{1'b0, 1'b0, 1'b0};

  initial begin
    exp_t e;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_sum", int'(sum8), 0);
    chk("rst_cout", int'(cout8), 0);
    rst = 1'b0;

    issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // start held high. A new operand is accepted only every 9 edges, and
    // the cycles in between carry junk operands.
    @(negedge clk);
    start8 = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i % 9 == 0) begin
        a8 = bb_a[i/9]; b8 = bb_b[i/9]; cin8 = bb_c[i/9];
        e.sum = bb_s[i/9]; e.cout = bb_co[i/9]; e.ovf = bb_o[i/9];
        e.cyc = cyc + 1 + 8;
        q8.push_back(e);
      end else begin
        a8 = 8'hE0 ^ 8'(i); b8 = ~8'(i); cin8 = i[0];
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the 4th RUN cycle: the operation is aborted and no done follows.
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_busy", int'(busy8), 0);
    chk("midrun_rst_done", int'(done8), 0);
    chk("midrun_rst_sum", int'(sum8), 0);
    chk("midrun_rst_cout", int'(cout8), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

    // W=1 instance: 1+1+1 = 0b11.
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    e.sum = 8'h01; e.cout = 1'b1; e.ovf = 1'b0; e.cyc = cyc + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 100 && (q8.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("w8_queue_drained", q8.size(), 0);
    chk("w1_queue_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
